// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage and forward_detection.
//   - Bit positions inside the 3-bit forward_detect vectors
//   - RV32I major opcodes and the bubble encoding (addi x0,x0,0)
//   - Control-bit struct carried through ID/EX
//   - uses_rs1/uses_rs2: which source registers an opcode really reads.
//     forward_detection uses the same functions so hazard and forwarding
//     decisions agree on operand usage.
package id_ex_operand_stage_pkg;

  localparam int FWD_W      = 3;
  localparam int FWD_IN_MEM = 0;  // producer of the EX operand is in MEM
  localparam int FWD_IN_WB  = 1;  // producer of the EX operand is in WB
  localparam int FWD_IN_ID  = 2;  // WB writes the register ID is reading now

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] CAL_I      = 7'b0010011;  // OP-IMM; bubble opcode

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP, CAL_I: uses_rs1 = 1'b1;
      default:                                                  uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPC_BRANCH, OPC_STORE, OPC_OP: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_bypass_mux.sv
// operand_bypass_mux: resolves one EX operand from the forward vector.
//   fwd            in  3     forward_detect bits (MEM / WB / ID)
//   reg_data       in  XLEN  operand data held in the ID/EX register
//   alu_result_MEM in  XLEN  value produced in MEM
//   wb_data_WB     in  XLEN  value written back in WB
//   operand        out XLEN  resolved operand (MEM beats WB beats register)
// The ID bit is consumed at capture time by the top, not here.
module operand_bypass_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [FWD_W-1:0] fwd,
  input  logic [XLEN-1:0]  reg_data,
  input  logic [XLEN-1:0]  alu_result_MEM,
  input  logic [XLEN-1:0]  wb_data_WB,
  output logic [XLEN-1:0]  operand
);

  logic unused_fwd_id;
  assign unused_fwd_id = fwd[FWD_IN_ID];

  always_comb begin
    operand = reg_data;
    if (fwd[FWD_IN_MEM])     operand = alu_result_MEM;
    else if (fwd[FWD_IN_WB]) operand = wb_data_WB;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX operand resolution.
//   clk, rst_n                    clock, async active-low reset
//   stall_i, flush_i              memory stall hold / kill ID instruction
//   *_ID                          decoded ID instruction and RF read data
//   forward_detect_rs1/rs2        forward bits (MEM / WB / ID)
//   alu_result_MEM, wb_data_WB    bypass sources
//   *_EX                          registered ID fields
//   operand_rs1_EX/rs2_EX         bypassed operands (combinational)
//   load_use_stall_o              freeze PC and IF/ID for one cycle
//   bubble_count                  saturating count of inserted bubbles
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int XLEN                = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall_i,
  input  logic                           flush_i,
  input  logic [XLEN-1:0]                pc_ID,
  input  logic [6:0]                     opcode_ID,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_ID,
  input  logic [XLEN-1:0]                imm_ID,
  input  logic [XLEN-1:0]                rs1_data_ID,
  input  logic [XLEN-1:0]                rs2_data_ID,
  input  logic                           reg_write_ID,
  input  logic                           mem_read_ID,
  input  logic                           mem_write_ID,
  input  logic [2:0]                     forward_detect_rs1,
  input  logic [2:0]                     forward_detect_rs2,
  input  logic [XLEN-1:0]                alu_result_MEM,
  input  logic [XLEN-1:0]                wb_data_WB,
  output logic [XLEN-1:0]                pc_EX,
  output logic [XLEN-1:0]                imm_EX,
  output logic [6:0]                     opcode_EX,
  output logic [REGISTER_ADDR_WIDTH-1:0] rs1_EX,
  output logic [REGISTER_ADDR_WIDTH-1:0] rs2_EX,
  output logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
  output logic                           reg_write_EX,
  output logic                           mem_read_EX,
  output logic                           mem_write_EX,
  output logic [XLEN-1:0]                operand_rs1_EX,
  output logic [XLEN-1:0]                operand_rs2_EX,
  output logic                           load_use_stall_o,
  output logic [31:0]                    bubble_count
);

  localparam int NUM_OPS = 2;

  logic [XLEN-1:0]                pc_q, imm_q;
  logic [6:0]                     opcode_q;
  logic [REGISTER_ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  ctrl_t                          ctrl_q, ctrl_id;
  logic                           pending_flush;
  logic [31:0]                    bc_q;

  logic [NUM_OPS-1:0][FWD_W-1:0] fwd;
  logic [NUM_OPS-1:0][XLEN-1:0]  rf_data_id, data_id, data_q, operand;

  assign fwd        = {forward_detect_rs2, forward_detect_rs1};
  assign rf_data_id = {rs2_data_ID, rs1_data_ID};
  assign ctrl_id    = '{reg_write: reg_write_ID, mem_read: mem_read_ID, mem_write: mem_write_ID};

  // Per operand: WB->ID bypass at capture, MEM/WB->EX bypass on the register.
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    assign data_id[g] = fwd[g][FWD_IN_ID] ? wb_data_WB : rf_data_id[g];

    operand_bypass_mux #(.XLEN(XLEN)) u_bypass (
      .fwd           (fwd[g]),
      .reg_data      (data_q[g]),
      .alu_result_MEM(alu_result_MEM),
      .wb_data_WB    (wb_data_WB),
      .operand       (operand[g])
    );
  end

  logic id_use_rs1, id_use_rs2, rs_hit;
  assign id_use_rs1 = uses_rs1(opcode_ID);
  assign id_use_rs2 = uses_rs2(opcode_ID);
  assign rs_hit     = (id_use_rs1 && (rs1_ID == rd_q)) || (id_use_rs2 && (rs2_ID == rd_q));
  // A flush kills the consumer in ID, so there is nothing to wait for.
  assign load_use_stall_o = ctrl_q.mem_read && (rd_q != '0) && rs_hit && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= '0;
      imm_q         <= '0;
      opcode_q      <= CAL_I;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      ctrl_q        <= CTRL_BUBBLE;
      data_q        <= '0;
      pending_flush <= 1'b0;
      bc_q          <= '0;
    end else if (stall_i) begin
      // Fields hold, but freeze the resolved operands: the bypass source
      // may drain out of MEM/WB before the stall releases.
      data_q <= operand;
      if (flush_i) pending_flush <= 1'b1;
    end else if (flush_i || pending_flush || load_use_stall_o) begin
      opcode_q      <= CAL_I;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      ctrl_q        <= CTRL_BUBBLE;
      data_q        <= '0;
      pending_flush <= 1'b0;
      if (bc_q != 32'hFFFF_FFFF) bc_q <= bc_q + 32'd1;
    end else begin
      pc_q     <= pc_ID;
      imm_q    <= imm_ID;
      opcode_q <= opcode_ID;
      rs1_q    <= rs1_ID;
      rs2_q    <= rs2_ID;
      rd_q     <= rd_ID;
      ctrl_q   <= ctrl_id;
      data_q   <= data_id;
    end
  end

  assign pc_EX          = pc_q;
  assign imm_EX         = imm_q;
  assign opcode_EX      = opcode_q;
  assign rs1_EX         = rs1_q;
  assign rs2_EX         = rs2_q;
  assign rd_EX          = rd_q;
  assign reg_write_EX   = ctrl_q.reg_write;
  assign mem_read_EX    = ctrl_q.mem_read;
  assign mem_write_EX   = ctrl_q.mem_write;
  assign operand_rs1_EX = operand[0];
  assign operand_rs2_EX = operand[1];
  assign bubble_count   = bc_q;

endmodule
